// File: rtl/disp_src_sched.sv
// disp_src_sched: decides which value source owns the 6-digit display path.
// Frequency owns the display by default; an amplitude or waveform update
// takes it over for HOLD_MS milliseconds, after which frequency is reloaded.
// Every (re)load produces a one-cycle disp_load strobe for the BCD converter.
// Optional feature macro: DISP_BLINK_EN (blinks the tubes while a hold source
// owns the display; when undefined disp_blank is tied low and no blink
// counter exists).
module disp_src_sched #(
  parameter int CLK_FREQ = 50000000,
  parameter int HOLD_MS  = 3000,
  parameter int BLINK_MS = 250,
  parameter int MAX_VAL  = 999999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] freq_val,
  input  logic        freq_upd,
  input  logic [19:0] amp_val,
  input  logic        amp_upd,
  input  logic [19:0] wave_val,
  input  logic        wave_upd,
  output logic [19:0] disp_bin,
  output logic [1:0]  disp_src,
  output logic        disp_load,
  output logic        disp_ovf,
  output logic        disp_blank
);

  // Prescaler divides clk down to a 1 ms tick; the ms counter then counts
  // ticks up to the hold time. Widths are guarded so terminal values of 1
  // still give a legal 1-bit counter.
  localparam int PRE_TERM = CLK_FREQ / 1000;
  localparam int PRE_W    = (PRE_TERM > 1) ? $clog2(PRE_TERM) : 1;
  localparam int HOLD_W   = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_TERM - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
  localparam logic [19:0]       MAX_V     = 20'(MAX_VAL);

  localparam logic [1:0] SRC_FREQ = 2'd0;
  localparam logic [1:0] SRC_AMP  = 2'd1;
  localparam logic [1:0] SRC_WAVE = 2'd2;

  typedef enum logic {
    S_FREQ = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [PRE_W-1:0]  presc_reg;
  logic [HOLD_W-1:0] ms_cnt_reg;
  logic              ms_tick;
  logic              hold_expire;

  logic              load_en;
  logic              restart;
  logic [19:0]       load_val;
  logic [1:0]        load_src;

  logic [19:0]       disp_bin_reg;
  logic [1:0]        disp_src_reg;
  logic              disp_load_reg;
  logic              disp_ovf_reg;

  // The ms tick only exists while a hold source owns the display, so expiry
  // can never fire in S_FREQ.
  assign ms_tick     = (state_reg == S_HOLD) && (presc_reg == PRE_LAST);
  assign hold_expire = ms_tick && (ms_cnt_reg == HOLD_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FREQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: any strobe beats expiry; freq beats amp beats wave.
  always_comb begin
    state_next = state_reg;
    if (freq_upd) begin
      state_next = S_FREQ;
    end else if (amp_upd || wave_upd) begin
      state_next = S_HOLD;
    end else if (hold_expire) begin
      state_next = S_FREQ;
    end
  end

  // Load decode: which value to latch, its tag, and whether the hold timer
  // restarts. Expiry reloads the live freq_val.
  always_comb begin
    load_en  = 1'b0;
    restart  = 1'b0;
    load_val = freq_val;
    load_src = SRC_FREQ;
    if (freq_upd) begin
      load_en = 1'b1;
    end else if (amp_upd) begin
      load_en  = 1'b1;
      restart  = 1'b1;
      load_val = amp_val;
      load_src = SRC_AMP;
    end else if (wave_upd) begin
      load_en  = 1'b1;
      restart  = 1'b1;
      load_val = wave_val;
      load_src = SRC_WAVE;
    end else if (hold_expire) begin
      load_en = 1'b1;
    end
  end

  // Hold timer: cleared on restart and whenever the display is not held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg  <= '0;
      ms_cnt_reg <= '0;
    end else if (restart || (state_next != S_HOLD)) begin
      presc_reg  <= '0;
      ms_cnt_reg <= '0;
    end else if (ms_tick) begin
      presc_reg  <= '0;
      ms_cnt_reg <= ms_cnt_reg + 1'b1;
    end else begin
      presc_reg  <= presc_reg + 1'b1;
    end
  end

  // Output registers: saturate to six digits and flag the saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bin_reg  <= '0;
      disp_src_reg  <= SRC_FREQ;
      disp_load_reg <= 1'b0;
      disp_ovf_reg  <= 1'b0;
    end else begin
      disp_load_reg <= load_en;
      if (load_en) begin
        disp_bin_reg <= (load_val > MAX_V) ? MAX_V : load_val;
        disp_ovf_reg <= (load_val > MAX_V);
        disp_src_reg <= load_src;
      end
    end
  end

  assign disp_bin  = disp_bin_reg;
  assign disp_src  = disp_src_reg;
  assign disp_load = disp_load_reg;
  assign disp_ovf  = disp_ovf_reg;

`ifdef DISP_BLINK_EN
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blank_reg;

  // Blink: toggle every BLINK_MS ticks while held; restart dark-off at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (restart || (state_next != S_HOLD)) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blank_reg     <= ~blank_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign disp_blank = blank_reg;
`else
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_disp_src_sched.sv
// tb_disp_src_sched: directed stimulus with a load scoreboard. Stimulus
// pushes the expected {value, source, overflow, cycle} of every disp_load
// pulse; the monitor pops one entry per observed pulse. 1 ms = 10 cycles.
module tb_disp_src_sched;

  typedef struct {
    int bin;
    int src;
    int ovf;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] freq_val = '0;
  logic        freq_upd = 1'b0;
  logic [19:0] amp_val = '0;
  logic        amp_upd = 1'b0;
  logic [19:0] wave_val = '0;
  logic        wave_upd = 1'b0;
  logic [19:0] disp_bin;
  logic [1:0]  disp_src;
  logic        disp_load;
  logic        disp_ovf;
  logic        disp_blank;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  disp_src_sched #(
    .CLK_FREQ(10000),
    .HOLD_MS (3),
    .BLINK_MS(1),
    .MAX_VAL (999999)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freq_val  (freq_val),
    .freq_upd  (freq_upd),
    .amp_val   (amp_val),
    .amp_upd   (amp_upd),
    .wave_val  (wave_val),
    .wave_upd  (wave_upd),
    .disp_bin  (disp_bin),
    .disp_src  (disp_src),
    .disp_load (disp_load),
    .disp_ovf  (disp_ovf),
    .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_load(input int bin, input int src, input int ovf, input int at);
    exp_t e;
    e.bin = bin;
    e.src = src;
    e.ovf = ovf;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; the strobes are sampled by the next edge.
  task automatic pulse(input logic f, input logic a, input logic w);
    freq_upd = f;
    amp_upd  = a;
    wave_upd = w;
    @(posedge clk);
    #1;
    freq_upd = 1'b0;
    amp_upd  = 1'b0;
    wave_upd = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every load pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && disp_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("load cyc=%0d bin=%0d src=%0d ovf=%0b", cyc, disp_bin, disp_src, disp_ovf);
        chk("load_bin", int'(disp_bin), e.bin);
        chk("load_src", int'(disp_src), e.src);
        chk("load_ovf", int'(disp_ovf), e.ovf);
        chk("load_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    int r;
    int exp_blank;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_bin", int'(disp_bin), 0);
    chk("rst_src", int'(disp_src), 0);
    chk("rst_load", int'(disp_load), 0);
    chk("rst_ovf", int'(disp_ovf), 0);
    chk("rst_blank", int'(disp_blank), 0);

    // 1: frequency load, latency 1.
    wait_to(5);
    freq_val = 20'd123456;
    expect_load(123456, 0, 0, cyc + 1);
    pulse(1'b1, 1'b0, 1'b0);

    // 2: amplitude hold, return to freq exactly 30 cycles after the restart edge.
    wait_to(20);
    amp_val = 20'd750;
    r = cyc + 1;
    expect_load(750, 1, 0, r);
    expect_load(123456, 0, 0, r + 30);
    pulse(1'b0, 1'b1, 1'b0);
    wait_to(r + 35);

    // 3: saturation and its release.
    freq_val = 20'd1048575;
    expect_load(999999, 0, 1, cyc + 1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(3);
    freq_val = 20'd5;
    expect_load(5, 0, 0, cyc + 1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(3);

    // 4: all three strobes together -> freq wins, no hold follows.
    freq_val = 20'd33;
    amp_val  = 20'd11;
    wave_val = 20'd22;
    expect_load(33, 0, 0, cyc + 1);
    pulse(1'b1, 1'b1, 1'b1);
    wait_cycles(40);
    // amp and wave together -> amp wins.
    r = cyc;
    expect_load(11, 1, 0, cyc + 1);
    pulse(1'b0, 1'b1, 1'b1);

    // 5: wave 25 cycles after amp switches owner and extends the hold.
    wait_to(r + 25);
    wave_val = 20'd44;
    expect_load(44, 2, 0, cyc + 1);
    expect_load(33, 0, 0, cyc + 31);
    pulse(1'b0, 1'b0, 1'b1);
    wait_cycles(35);
    // freq mid-hold cuts the hold short; no expiry load afterwards.
    amp_val = 20'd66;
    expect_load(66, 1, 0, cyc + 1);
    pulse(1'b0, 1'b1, 1'b0);
    wait_cycles(10);
    freq_val = 20'd77;
    expect_load(77, 0, 0, cyc + 1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(40);

    // 6: blank pattern through a full hold and after the return.
    amp_val = 20'd88;
    r = cyc + 1;
    expect_load(88, 1, 0, r);
    expect_load(77, 0, 0, r + 30);
    pulse(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 35; k++) begin
`ifdef DISP_BLINK_EN
      exp_blank = ((k < 30) && (((k / 10) % 2) == 1)) ? 1 : 0;
`else
      exp_blank = 0;
`endif
      chk("blank", int'(disp_blank), exp_blank);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a hold.
    amp_val = 20'd99;
    expect_load(99, 1, 0, cyc + 1);
    pulse(1'b0, 1'b1, 1'b0);
    wait_cycles(15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bin", int'(disp_bin), 0);
    chk("arst_src", int'(disp_src), 0);
    chk("arst_load", int'(disp_load), 0);
    chk("arst_ovf", int'(disp_ovf), 0);
    chk("arst_blank", int'(disp_blank), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Display stays at 0 with no loads until the next strobe.
    wait_cycles(40);
    chk("post_rst_bin", int'(disp_bin), 0);
    chk("post_rst_src", int'(disp_src), 0);

    chk("pending_loads", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
